// File: rtl/tanh_scheduler.sv
// tanh_scheduler: round-robin front end that shares one combinational tanh
// unit among NUM_REQ requesters. Each accepted operand is held on
// tanh_in_data for a coefficient-latch cycle (LOAD) and a multiply cycle
// (CAPTURE), and the result is then offered on the response channel.
// Optional feature macro: TANH_SCHED_SAT_BYPASS_EN. When it is defined,
// operands above +2.0 or at/below -2.0 skip the unit and return a saturated
// +/-1.0 straight from IDLE.
module tanh_scheduler #(
  parameter int NUM_REQ = 4,
  parameter int DATA_W  = 16
) (
  input  logic                         clock,
  input  logic                         reset,
  input  logic [NUM_REQ-1:0]           req_valid,
  input  logic [NUM_REQ*DATA_W-1:0]    req_data,
  output logic [NUM_REQ-1:0]           req_ready,
  output logic [DATA_W-1:0]            tanh_in_data,
  input  logic [DATA_W-1:0]            tanh_out_data,
  output logic                         resp_valid,
  output logic [DATA_W-1:0]            resp_data,
  output logic [$clog2(NUM_REQ)-1:0]   resp_id,
  input  logic                         resp_ready,
  output logic                         busy
);

  localparam int ID_W = $clog2(NUM_REQ);

  typedef enum logic [1:0] {IDLE, LOAD, CAPTURE, RESP} state_e;

  state_e            state_q, state_d;
  logic [ID_W-1:0]   rrPtr_q, rrPtr_d;
  logic [DATA_W-1:0] op_q, op_d;
  logic [ID_W-1:0]   id_q, id_d;
  logic [DATA_W-1:0] respData_q, respData_d;

  logic              grantFound;
  logic [ID_W-1:0]   grantIdx;
  logic [ID_W:0]     candIdx;
  logic [DATA_W-1:0] grantOp;
  logic [ID_W-1:0]   nextPtr;

`ifdef TANH_SCHED_SAT_BYPASS_EN
  // Q9.7 thresholds: +/-2.0 is +/-256, +/-1.0 is +/-128.
  localparam logic signed [DATA_W-1:0] SAT_HI  = DATA_W'(256);
  localparam logic signed [DATA_W-1:0] SAT_LO  = DATA_W'(-256);
  localparam logic        [DATA_W-1:0] ONE_POS = DATA_W'(128);
  localparam logic        [DATA_W-1:0] ONE_NEG = DATA_W'(-128);
`endif

  // Round-robin search: the first valid requester at or after rrPtr_q wins.
  always_comb begin
    grantFound = 1'b0;
    grantIdx   = '0;
    candIdx    = '0;
    for (int i = 0; i < NUM_REQ; i++) begin
      candIdx = {1'b0, rrPtr_q} + (ID_W+1)'(i);
      if (candIdx >= (ID_W+1)'(NUM_REQ)) begin
        candIdx = candIdx - (ID_W+1)'(NUM_REQ);
      end
      if (!grantFound && req_valid[candIdx[ID_W-1:0]]) begin
        grantFound = 1'b1;
        grantIdx   = candIdx[ID_W-1:0];
      end
    end
  end

  assign grantOp = req_data[grantIdx*DATA_W +: DATA_W];
  assign nextPtr = (grantIdx == ID_W'(NUM_REQ-1)) ? '0 : grantIdx + 1'b1;

  // Next-state logic: grant in IDLE, walk the unit's two cycles, hold the response.
  always_comb begin
    state_d    = state_q;
    rrPtr_d    = rrPtr_q;
    op_d       = op_q;
    id_d       = id_q;
    respData_d = respData_q;
    req_ready  = '0;
    unique case (state_q)
      IDLE: begin
        if (grantFound) begin
          req_ready = NUM_REQ'(1) << grantIdx;
          op_d      = grantOp;
          id_d      = grantIdx;
          rrPtr_d   = nextPtr;
          state_d   = LOAD;
`ifdef TANH_SCHED_SAT_BYPASS_EN
          if ($signed(grantOp) > SAT_HI) begin
            respData_d = ONE_POS;
            state_d    = RESP;
          end else if ($signed(grantOp) <= SAT_LO) begin
            respData_d = ONE_NEG;
            state_d    = RESP;
          end
`endif
        end
      end
      LOAD: begin
        state_d = CAPTURE;
      end
      CAPTURE: begin
        respData_d = tanh_out_data;
        state_d    = RESP;
      end
      RESP: begin
        if (resp_ready) begin
          state_d = IDLE;
        end
      end
      default: begin
        state_d = IDLE;
      end
    endcase
    if (!reset) begin
      req_ready = '0;
    end
  end

  // State and datapath registers; reset abandons any operation in flight.
  always_ff @(posedge clock or negedge reset) begin
    if (!reset) begin
      state_q    <= IDLE;
      rrPtr_q    <= '0;
      op_q       <= '0;
      id_q       <= '0;
      respData_q <= '0;
    end else begin
      state_q    <= state_d;
      rrPtr_q    <= rrPtr_d;
      op_q       <= op_d;
      id_q       <= id_d;
      respData_q <= respData_d;
    end
  end

  assign tanh_in_data = op_q;
  assign resp_data    = respData_q;
  assign resp_id      = id_q;
  assign resp_valid   = (state_q == RESP);
  assign busy         = (state_q != IDLE);

endmodule

// File: tb/tb_tanh_scheduler.sv
// tb_tanh_scheduler: self-checking bench for tanh_scheduler with a stand-in
// combinational tanh unit and a transaction-level reference model.
module tb_tanh_scheduler;

  localparam int NUM_REQ = 4;
  localparam int DATA_W  = 16;

  logic                      clock;
  logic                      reset;
  logic [NUM_REQ-1:0]        reqValid;
  logic [NUM_REQ*DATA_W-1:0] reqData;
  logic [NUM_REQ-1:0]        reqReady;
  logic [DATA_W-1:0]         tanhIn;
  logic [DATA_W-1:0]         tanhOut;
  logic                      respValid;
  logic [DATA_W-1:0]         respData;
  logic [1:0]                respId;
  logic                      respReady;
  logic                      busy;

  int total;
  int bad;

  tanh_scheduler #(.NUM_REQ(NUM_REQ), .DATA_W(DATA_W)) dut (
    .clock        (clock),
    .reset        (reset),
    .req_valid    (reqValid),
    .req_data     (reqData),
    .req_ready    (reqReady),
    .tanh_in_data (tanhIn),
    .tanh_out_data(tanhOut),
    .resp_valid   (respValid),
    .resp_data    (respData),
    .resp_id      (respId),
    .resp_ready   (respReady),
    .busy         (busy)
  );

  // Free-running clock, period 10.
  initial begin
    clock = 1'b0;
    forever #5 clock = ~clock;
  end

  // Stand-in tanh unit: any distinctive combinational function of its input.
  function automatic logic [15:0] unitModel(input logic [15:0] x);
    return {x[7:0], x[15:8]} ^ 16'h5A3C;
  endfunction

  assign tanhOut = unitModel(tanhIn);

  // Expected response value for an operand.
  function automatic logic [15:0] expResult(input logic [15:0] op);
`ifdef TANH_SCHED_SAT_BYPASS_EN
    if ($signed(op) > 16'sd256)   return 16'h0080;
    if ($signed(op) <= -16'sd256) return 16'hFF80;
`endif
    return unitModel(op);
  endfunction

  // Expected cycles from grant to first resp_valid.
  function automatic int expLatency(input logic [15:0] op);
`ifdef TANH_SCHED_SAT_BYPASS_EN
    if ($signed(op) > 16'sd256 || $signed(op) <= -16'sd256) return 1;
`endif
    return 3;
  endfunction

  // Round-robin rule: first valid requester scanning upward from ptr.
  function automatic int pickWinner(input logic [3:0] v, input int ptr);
    for (int i = 0; i < NUM_REQ; i++) begin
      if (v[(ptr + i) % NUM_REQ]) return (ptr + i) % NUM_REQ;
    end
    return -1;
  endfunction

  task automatic doReset();
    reset     = 1'b0;
    reqValid  = '0;
    respReady = 1'b0;
    repeat (2) @(negedge clock);
    reset = 1'b1;
  endtask

  task automatic test_reset();
    reset     = 1'b0;
    reqValid  = 4'hF;
    reqData   = {$urandom, $urandom};
    respReady = 1'b1;
    for (int k = 0; k < 2; k++) begin
      #1;
      total++; if (reqReady !== 4'h0) begin bad++; $display("[TB] FAIL reset_req_ready: got %h expected 0", reqReady); end
      total++; if (respValid !== 1'b0) begin bad++; $display("[TB] FAIL reset_resp_valid: got %b expected 0", respValid); end
      total++; if (busy !== 1'b0) begin bad++; $display("[TB] FAIL reset_busy: got %b expected 0", busy); end
      total++; if (tanhIn !== 16'h0) begin bad++; $display("[TB] FAIL reset_tanh_in: got %h expected 0", tanhIn); end
      total++; if (respData !== 16'h0) begin bad++; $display("[TB] FAIL reset_resp_data: got %h expected 0", respData); end
      total++; if (respId !== 2'd0) begin bad++; $display("[TB] FAIL reset_resp_id: got %0d expected 0", respId); end
      @(negedge clock);
    end
  endtask

  task automatic test_single();
    int g, r, pulses;
    doReset();
    g = -1; r = -1; pulses = 0;
    reqData = '0;
    reqData[2*DATA_W +: DATA_W] = 16'h0040;
    reqValid  = 4'b0100;
    respReady = 1'b1;
    for (int c = 0; c < 8; c++) begin
      #1;
      if (reqReady !== 4'h0) begin
        pulses++;
        if (g < 0) g = c;
        total++; if (reqReady !== 4'b0100) begin bad++; $display("[TB] FAIL single_grant: got %b expected 0100", reqReady); end
      end
      if (g >= 0 && (c == g + 1 || c == g + 2)) begin
        total++; if (tanhIn !== 16'h0040) begin bad++; $display("[TB] FAIL single_tanh_in: cycle %0d got %h expected 0040", c - g, tanhIn); end
      end
      if (respValid === 1'b1 && r < 0) begin
        r = c;
        total++; if (r - g !== 3) begin bad++; $display("[TB] FAIL single_latency: got %0d expected 3", r - g); end
        total++; if (respId !== 2'd2) begin bad++; $display("[TB] FAIL single_resp_id: got %0d expected 2", respId); end
        total++; if (respData !== unitModel(16'h0040)) begin bad++; $display("[TB] FAIL single_resp_data: got %h expected %h", respData, unitModel(16'h0040)); end
      end
      @(negedge clock);
      if (g >= 0) reqValid = 4'b0000;
    end
    total++; if (pulses !== 1) begin bad++; $display("[TB] FAIL single_pulses: got %0d expected 1", pulses); end
    total++; if (r < 0) begin bad++; $display("[TB] FAIL single_resp_seen: got none expected one"); end
  endtask

  task automatic test_round_robin();
    int nGrant, lastId;
    logic [15:0] ops [4];
    doReset();
    for (int k = 0; k < NUM_REQ; k++) begin
      ops[k] = 16'($urandom_range(0, 510)) - 16'd255;
      reqData[k*DATA_W +: DATA_W] = ops[k];
    end
    reqValid  = 4'hF;
    respReady = 1'b1;
    nGrant = 0; lastId = -1;
    for (int c = 0; c < 20; c++) begin
      #1;
      if (reqReady !== 4'h0) begin
        total++;
        if (reqReady !== (4'b0001 << (nGrant % NUM_REQ)) || c != nGrant * 4) begin
          bad++; $display("[TB] FAIL rr_grant: got %b at cycle %0d expected %b at cycle %0d", reqReady, c, 4'b0001 << (nGrant % NUM_REQ), nGrant * 4);
        end
        lastId = nGrant % NUM_REQ;
        nGrant++;
      end
      if (respValid === 1'b1 && lastId >= 0) begin
        total++; if (respId !== 2'(lastId) || respData !== expResult(ops[lastId])) begin
          bad++; $display("[TB] FAIL rr_resp: got id %0d data %h expected id %0d data %h", respId, respData, lastId, expResult(ops[lastId]));
        end
      end
      @(negedge clock);
    end
    total++; if (nGrant !== 5) begin bad++; $display("[TB] FAIL rr_count: got %0d expected 5", nGrant); end
    reqValid = '0;
  endtask

  task automatic test_backpressure();
    bit found;
    logic [15:0] op;
    doReset();
    op = 16'($urandom_range(0, 510)) - 16'd255;
    reqData = {$urandom, $urandom};
    reqData[1*DATA_W +: DATA_W] = op;
    reqValid  = 4'b0010;
    respReady = 1'b0;
    found = 0;
    for (int c = 0; c < 8 && !found; c++) begin
      #1;
      if (reqReady !== 4'h0) found = 1;
      else @(negedge clock);
    end
    total++; if (!found || reqReady !== 4'b0010) begin bad++; $display("[TB] FAIL bp_grant: got %b expected 0010", reqReady); end
    @(negedge clock);
    reqValid = 4'b1000;
    found = 0;
    for (int c = 0; c < 8 && !found; c++) begin
      #1;
      if (respValid === 1'b1) found = 1;
      else begin
        total++; if (reqReady !== 4'h0) begin bad++; $display("[TB] FAIL bp_busy_ready: got %b expected 0000", reqReady); end
        @(negedge clock);
      end
    end
    total++; if (!found) begin bad++; $display("[TB] FAIL bp_resp_seen: got none expected one"); end
    for (int s = 0; s < 6; s++) begin
      if (s > 0) begin
        @(negedge clock);
        #1;
      end
      total++; if (respValid !== 1'b1 || respData !== expResult(op) || respId !== 2'd1 || reqReady !== 4'h0) begin
        bad++; $display("[TB] FAIL bp_stall: stall %0d got v=%b d=%h id=%0d rdy=%b expected v=1 d=%h id=1 rdy=0000", s, respValid, respData, respId, reqReady, expResult(op));
      end
    end
    @(negedge clock);
    respReady = 1'b1;
    #1;
    total++; if (reqReady !== 4'h0 || respValid !== 1'b1) begin bad++; $display("[TB] FAIL bp_handshake: got v=%b rdy=%b expected v=1 rdy=0000", respValid, reqReady); end
    @(negedge clock);
    #1;
    total++; if (reqReady !== 4'b1000 || respValid !== 1'b0) begin bad++; $display("[TB] FAIL bp_next_grant: got v=%b rdy=%b expected v=0 rdy=1000", respValid, reqReady); end
    @(negedge clock);
    reqValid = '0;
    repeat (4) @(negedge clock);
  endtask

  task automatic test_bypass();
    logic [15:0] ops [6];
    int g, r;
    ops[0] = 16'h0200; ops[1] = 16'hFE00; ops[2] = 16'h0100;
    ops[3] = 16'h0101; ops[4] = 16'hFF00; ops[5] = 16'hFF01;
    doReset();
    respReady = 1'b1;
    for (int n = 0; n < 6; n++) begin
      g = -1; r = -1;
      reqData = {$urandom, $urandom};
      reqData[1*DATA_W +: DATA_W] = ops[n];
      reqValid = 4'b0010;
      for (int c = 0; c < 8; c++) begin
        #1;
        if (reqReady !== 4'h0 && g < 0) begin
          g = c;
          total++; if (reqReady !== 4'b0010) begin bad++; $display("[TB] FAIL byp_grant: op %h got %b expected 0010", ops[n], reqReady); end
        end
        if (respValid === 1'b1 && r < 0) begin
          r = c;
          total++; if (r - g !== expLatency(ops[n])) begin bad++; $display("[TB] FAIL byp_latency: op %h got %0d expected %0d", ops[n], r - g, expLatency(ops[n])); end
          total++; if (respData !== expResult(ops[n]) || respId !== 2'd1) begin bad++; $display("[TB] FAIL byp_resp: op %h got d=%h id=%0d expected d=%h id=1", ops[n], respData, respId, expResult(ops[n])); end
          total++; if (tanhIn !== ops[n]) begin bad++; $display("[TB] FAIL byp_op_held: got %h expected %h", tanhIn, ops[n]); end
        end
        @(negedge clock);
        if (g >= 0) reqValid = 4'b0000;
      end
      total++; if (g < 0 || r < 0) begin bad++; $display("[TB] FAIL byp_seen: op %h grant %0d resp %0d expected both", ops[n], g, r); end
    end
  endtask

  task automatic test_reset_mid();
    bit found;
    doReset();
    reqData = {$urandom, $urandom};
    reqData[2*DATA_W +: DATA_W] = 16'($urandom_range(0, 510)) - 16'd255;
    reqValid  = 4'b0100;
    respReady = 1'b1;
    found = 0;
    for (int c = 0; c < 8 && !found; c++) begin
      #1;
      if (reqReady !== 4'h0) found = 1;
      else @(negedge clock);
    end
    total++; if (!found) begin bad++; $display("[TB] FAIL rst_mid_grant: got none expected 0100"); end
    @(negedge clock);
    reqValid = 4'b0000;
    @(negedge clock);
    #1;
    total++; if (busy !== 1'b1 || respValid !== 1'b0) begin bad++; $display("[TB] FAIL rst_mid_capture: got busy=%b v=%b expected busy=1 v=0", busy, respValid); end
    reset = 1'b0;
    reqValid = 4'b1001;
    #1;
    for (int s = 0; s < 3; s++) begin
      total++; if ({respValid, busy, reqReady, tanhIn, respData, respId} !== '0) begin
        bad++; $display("[TB] FAIL rst_mid_outputs: got v=%b busy=%b rdy=%b in=%h d=%h id=%0d expected all 0", respValid, busy, reqReady, tanhIn, respData, respId);
      end
      @(negedge clock);
      #1;
    end
    @(negedge clock);
    reset = 1'b1;
    #1;
    total++; if (reqReady !== 4'b0001 || respValid !== 1'b0) begin bad++; $display("[TB] FAIL rst_mid_regrant: got rdy=%b v=%b expected rdy=0001 v=0", reqReady, respValid); end
    @(negedge clock);
    reqValid = '0;
    repeat (4) @(negedge clock);
  endtask

  task automatic test_random();
    bit pending;
    int pendId, readyCyc, rrModel, w;
    logic [15:0] pendData, op;
    logic [3:0] expGrant;
    bit expValid;
    doReset();
    rrModel = 0;
    pending = 0; pendId = 0; readyCyc = 0; pendData = '0;
    for (int c = 0; c < 400; c++) begin
      reqValid = 4'($urandom);
      for (int k = 0; k < NUM_REQ; k++) reqData[k*DATA_W +: DATA_W] = 16'($urandom);
      respReady = ($urandom_range(0, 3) != 0);
      #1;
      expGrant = 4'h0; w = -1;
      if (!pending && reqValid != 4'h0) begin
        w = pickWinner(reqValid, rrModel);
        expGrant = 4'b0001 << w;
      end
      expValid = pending && (c >= readyCyc);
      total++; if (reqReady !== expGrant) begin bad++; $display("[TB] FAIL rand_grant: cycle %0d got %b expected %b", c, reqReady, expGrant); end
      total++; if (busy !== pending) begin bad++; $display("[TB] FAIL rand_busy: cycle %0d got %b expected %b", c, busy, pending); end
      total++; if (respValid !== expValid) begin bad++; $display("[TB] FAIL rand_resp_valid: cycle %0d got %b expected %b", c, respValid, expValid); end
      if (expValid) begin
        total++; if (respData !== pendData || respId !== 2'(pendId)) begin
          bad++; $display("[TB] FAIL rand_resp: cycle %0d got d=%h id=%0d expected d=%h id=%0d", c, respData, respId, pendData, pendId);
        end
      end
      if (expValid && respReady) begin
        pending = 0;
      end else if (w >= 0) begin
        op       = reqData[w*DATA_W +: DATA_W];
        pending  = 1;
        pendId   = w;
        pendData = expResult(op);
        readyCyc = c + expLatency(op);
        rrModel  = (w + 1) % NUM_REQ;
      end
      @(negedge clock);
    end
    reqValid = '0;
    respReady = 1'b1;
    repeat (5) @(negedge clock);
  endtask

  // Watchdog so a stuck run still ends with a report.
  initial begin
    #200000;
    $display("[TB] FAIL watchdog: got timeout expected completion");
    $fatal(1, "[TB] watchdog expired");
  end

  // Test sequence.
  initial begin
    total = 0;
    bad = 0;
    reset = 1'b0;
    reqValid = '0;
    reqData = '0;
    respReady = 1'b0;
    @(negedge clock);
    test_reset();
    test_single();
    test_round_robin();
    test_backpressure();
    test_bypass();
    test_reset_mid();
    test_random();
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
